// File: rtl/fb_scanout.sv
// Framebuffer scan-out: raster-order BRAM reads feed a credit-limited prefetch FIFO and a pixel stream.
// Latency: first pix_valid 3 cycles after frame_start is sampled; 1 pixel/clk sustained after fill.
// Backpressure: pix_ready low holds the beat; reads stop once FIFO entries plus in-flight reads reach FIFO_DEPTH.
module fb_scanout #(
    parameter int H_RES      = 800,
    parameter int V_RES      = 480,
    parameter int PIX_DATAW  = 4,
    parameter int PACKED     = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDRW      = 19
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_start,
    output logic                              fb_en,
    output logic [ADDRW-1:0]                  fb_addr,
    input  logic [PIX_DATAW*(PACKED+1)-1:0]   fb_data,
    output logic [PIX_DATAW-1:0]              pix,
    output logic                              pix_valid,
    input  logic                              pix_ready,
    output logic                              pix_eol,
    output logic                              pix_eof,
    output logic                              busy
);

    localparam int WORDW = PIX_DATAW * (PACKED + 1);
    localparam int WORDS = H_RES * V_RES / (PACKED + 1);
    localparam int PTRW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW  = PTRW + 1;
    localparam int XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW    = (V_RES > 1) ? $clog2(V_RES) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state;
    logic [ADDRW-1:0]    rd_ptr;
    logic                rd_vld;
    logic [WORDW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTRW-1:0]     wr_idx;
    logic [PTRW-1:0]     rd_idx;
    logic [CNTW-1:0]     fifo_cnt;
    logic                nibble_sel;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;

    logic [CNTW:0]       outstanding;
    logic                issue;
    logic                load;
    logic                pop;
    logic                push;
    logic [WORDW-1:0]    head_word;
    logic [PIX_DATAW-1:0] next_pix;
    logic                last_x;
    logic                last_y;

    // Reads already issued (fb_en) or on the bus (rd_vld) hold a FIFO slot in advance.
    assign outstanding = (CNTW+1)'(fifo_cnt) + (CNTW+1)'(fb_en) + (CNTW+1)'(rd_vld);
    assign issue       = (state == FETCH) && (outstanding < (CNTW+1)'(FIFO_DEPTH));
    assign push        = rd_vld;
    assign load        = (!pix_valid || pix_ready) && (fifo_cnt != '0);
    assign pop         = load && ((PACKED == 0) || nibble_sel);
    assign head_word   = fifo_mem[rd_idx];
    assign next_pix    = ((PACKED != 0) && nibble_sel) ? head_word[WORDW-1 -: PIX_DATAW]
                                                       : head_word[PIX_DATAW-1:0];
    assign last_x      = (x == XW'(H_RES - 1));
    assign last_y      = (y == YW'(V_RES - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_idx] <= fb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            fb_en      <= 1'b0;
            fb_addr    <= '0;
            rd_ptr     <= '0;
            rd_vld     <= 1'b0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            fifo_cnt   <= '0;
            nibble_sel <= 1'b0;
            x          <= '0;
            y          <= '0;
            pix        <= '0;
            pix_valid  <= 1'b0;
            pix_eol    <= 1'b0;
            pix_eof    <= 1'b0;
        end else begin
            rd_vld <= fb_en;
            fb_en  <= 1'b0;

            case (state)
                IDLE: begin
                    // Word 0 is requested on the same edge that starts the frame.
                    if (frame_start) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        fb_en   <= 1'b1;
                        fb_addr <= '0;
                        rd_ptr  <= ADDRW'(1);
                    end
                end
                FETCH: begin
                    if (issue) begin
                        fb_en   <= 1'b1;
                        fb_addr <= rd_ptr;
                        rd_ptr  <= rd_ptr + 1'b1;
                        if (rd_ptr == ADDRW'(WORDS - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pix_valid && pix_ready && pix_eof) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (push) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end

            // Output register: x/y name the pixel being loaded, so eol/eof travel with it.
            if (load) begin
                pix       <= next_pix;
                pix_valid <= 1'b1;
                pix_eol   <= last_x;
                pix_eof   <= last_x && last_y;
                if (PACKED != 0) begin
                    nibble_sel <= !nibble_sel;
                end
                if (last_x) begin
                    x <= '0;
                    y <= last_y ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: two small instances (unpacked 4x2 depth 2, packed 10x6 depth 4) checked by scoreboards.
module tb_fb_scanout;

    localparam int H_A = 4,  V_A = 2, NPIX_A = H_A * V_A, WORDS_A = NPIX_A;
    localparam int H_B = 10, V_B = 6, NPIX_B = H_B * V_B, WORDS_B = NPIX_B / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fs_a = 1'b0, fs_b = 1'b0;
    logic pix_ready_a = 1'b0, pix_ready_b = 1'b0;

    logic        fb_en_a, fb_en_b;
    logic [18:0] fb_addr_a, fb_addr_b;
    logic [3:0]  fb_data_a = '0;
    logic [7:0]  fb_data_b = '0;
    logic [3:0]  pix_a, pix_b;
    logic        pix_valid_a, pix_valid_b, pix_eol_a, pix_eol_b, pix_eof_a, pix_eof_b;
    logic        busy_a, busy_b;

    logic [3:0] mem_a [WORDS_A];
    logic [7:0] mem_b [WORDS_B];
    logic [5:0] qa [$];
    logic [5:0] qb [$];

    int checks = 0;
    int errors = 0;
    int mode = 0;
    int exp_addr_a = 0, exp_addr_b = 0;
    logic hold_a = 1'b0, hold_b = 1'b0;
    logic [5:0] prev_a = '0, prev_b = '0;

    fb_scanout #(.H_RES(H_A), .V_RES(V_A), .PIX_DATAW(4), .PACKED(0), .FIFO_DEPTH(2), .ADDRW(19)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .fb_en(fb_en_a), .fb_addr(fb_addr_a),
        .fb_data(fb_data_a), .pix(pix_a), .pix_valid(pix_valid_a), .pix_ready(pix_ready_a),
        .pix_eol(pix_eol_a), .pix_eof(pix_eof_a), .busy(busy_a));

    fb_scanout #(.H_RES(H_B), .V_RES(V_B), .PIX_DATAW(4), .PACKED(1), .FIFO_DEPTH(4), .ADDRW(19)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .fb_en(fb_en_b), .fb_addr(fb_addr_b),
        .fb_data(fb_data_b), .pix(pix_b), .pix_valid(pix_valid_b), .pix_ready(pix_ready_b),
        .pix_eol(pix_eol_b), .pix_eof(pix_eof_b), .busy(busy_b));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous BRAM models, one cycle read latency.
    always @(posedge clk) begin
        if (fb_en_a && int'(fb_addr_a) < WORDS_A) fb_data_a <= mem_a[int'(fb_addr_a)];
        if (fb_en_b && int'(fb_addr_b) < WORDS_B) fb_data_b <= mem_b[int'(fb_addr_b)];
    end

    // Sink: 0 = always ready, 1 = ready 30% of cycles, 2 = stalled.
    always @(posedge clk) begin
        #1;
        case (mode)
            1: begin
                pix_ready_a = ($urandom_range(0, 99) < 30);
                pix_ready_b = ($urandom_range(0, 99) < 30);
            end
            2: begin
                pix_ready_a = 1'b0;
                pix_ready_b = 1'b0;
            end
            default: begin
                pix_ready_a = 1'b1;
                pix_ready_b = 1'b1;
            end
        endcase
    end

    // Monitors: read address sequence, beat stability under stall, scoreboard pops.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_a = 1'b0;
            hold_b = 1'b0;
        end else begin
            if (fb_en_a) begin chk("addr_a", 32'(fb_addr_a), 32'(exp_addr_a)); exp_addr_a++; end
            if (fb_en_b) begin chk("addr_b", 32'(fb_addr_b), 32'(exp_addr_b)); exp_addr_b++; end

            if (hold_a) chk("hold_a", {pix_valid_a, pix_eol_a, pix_eof_a, pix_a}, {1'b1, prev_a});
            if (hold_b) chk("hold_b", {pix_valid_b, pix_eol_b, pix_eof_b, pix_b}, {1'b1, prev_b});

            if (pix_valid_a && pix_ready_a) begin
                if (qa.size() == 0) chk("extra_beat_a", 1, 0);
                else chk("beat_a", {pix_eol_a, pix_eof_a, pix_a}, qa.pop_front());
            end
            if (pix_valid_b && pix_ready_b) begin
                if (qb.size() == 0) chk("extra_beat_b", 1, 0);
                else chk("beat_b", {pix_eol_b, pix_eof_b, pix_b}, qb.pop_front());
            end

            hold_a = pix_valid_a && !pix_ready_a;
            hold_b = pix_valid_b && !pix_ready_b;
            prev_a = {pix_eol_a, pix_eof_a, pix_a};
            prev_b = {pix_eol_b, pix_eof_b, pix_b};
        end
    end

    // Fill both framebuffers, build the golden pixel streams, start both frames.
    task automatic start_frames();
        logic [7:0] w;
        logic [3:0] nib;
        logic va, vb;
        foreach (mem_a[i]) mem_a[i] = 4'($urandom);
        foreach (mem_b[i]) mem_b[i] = 8'($urandom);
        for (int p = 0; p < NPIX_A; p++)
            qa.push_back({(p % H_A) == H_A - 1, p == NPIX_A - 1, mem_a[p]});
        for (int p = 0; p < NPIX_B; p++) begin
            w = mem_b[p / 2];
            nib = (p % 2 == 1) ? w[7:4] : w[3:0];
            qb.push_back({(p % H_B) == H_B - 1, p == NPIX_B - 1, nib});
        end
        exp_addr_a = 0;
        exp_addr_b = 0;
        @(posedge clk); #1;
        fs_a = 1'b1; fs_b = 1'b1;
        @(posedge clk); #1;
        fs_a = 1'b0; fs_b = 1'b0;
        chk("busy_after_start_a", busy_a, 1);
        chk("busy_after_start_b", busy_b, 1);
        va = 1'b0; vb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            va = va | pix_valid_a;
            vb = vb | pix_valid_b;
        end
        chk("first_valid_a", va, 1);
        chk("first_valid_b", vb, 1);
    endtask

    // Wait for both frames to finish (bounded), optionally pulsing frame_start while busy.
    task automatic wait_done(input bit spam);
        int n = 0;
        while ((busy_a || busy_b) && n < 3000) begin
            @(posedge clk); #1;
            fs_a = spam && busy_a && ($urandom_range(0, 3) == 0);
            fs_b = spam && busy_b && ($urandom_range(0, 3) == 0);
            n++;
        end
        fs_a = 1'b0; fs_b = 1'b0;
        chk("frame_timeout", n < 3000, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after_a", busy_a, 0);
        chk("idle_after_b", busy_b, 0);
        chk("left_a", qa.size(), 0);
        chk("left_b", qb.size(), 0);
        chk("reads_a", exp_addr_a, WORDS_A);
        chk("reads_b", exp_addr_b, WORDS_B);
    endtask

    initial begin
        int en_a, en_b;
        #7;
        chk("rst_fb_en_a", fb_en_a, 0);     chk("rst_fb_en_b", fb_en_b, 0);
        chk("rst_fb_addr_a", fb_addr_a, 0); chk("rst_fb_addr_b", fb_addr_b, 0);
        chk("rst_pix_a", pix_a, 0);         chk("rst_pix_b", pix_b, 0);
        chk("rst_valid_a", pix_valid_a, 0); chk("rst_valid_b", pix_valid_b, 0);
        chk("rst_eol_a", pix_eol_a, 0);     chk("rst_eof_b", pix_eof_b, 0);
        chk("rst_busy_a", busy_a, 0);       chk("rst_busy_b", busy_b, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full-rate frame.
        mode = 0;
        start_frames();
        wait_done(1'b0);

        // Random 30% ready with frame_start pulses during FETCH and DRAIN.
        @(negedge clk) mode = 1;
        start_frames();
        wait_done(1'b1);

        // Long stall mid-line: reads must stop once the prefetch is full.
        @(negedge clk) mode = 0;
        start_frames();
        repeat (2) @(posedge clk);
        @(negedge clk) mode = 2;
        en_a = 0; en_b = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #2;
            if (c >= 10 && fb_en_a) en_a++;
            if (c >= 10 && fb_en_b) en_b++;
        end
        chk("stall_reads_a", en_a, 0);
        chk("stall_reads_b", en_b, 0);
        @(negedge clk) mode = 0;
        wait_done(1'b0);

        // Asynchronous reset in the middle of FETCH.
        start_frames();
        @(posedge clk); #1;
        chk("busy_before_rst_b", busy_b, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_fb_en_a", fb_en_a, 0);     chk("arst_fb_en_b", fb_en_b, 0);
        chk("arst_valid_a", pix_valid_a, 0); chk("arst_valid_b", pix_valid_b, 0);
        chk("arst_busy_a", busy_a, 0);       chk("arst_busy_b", busy_b, 0);
        qa.delete();
        qb.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_busy_a", busy_a, 0);
        chk("post_rst_busy_b", busy_b, 0);
        chk("post_rst_valid_b", pix_valid_b, 0);

        // Recovery frame after reset, random backpressure.
        @(negedge clk) mode = 1;
        start_frames();
        wait_done(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
